pwm_audio_sched: RTL and testbench
==================================

# pwm_audio_sched

Sample scheduler for the stereo PWM audio DACs. It owns the 128-step PWM period timebase, buffers host-written 7-bit samples per channel, and loads the left and right PWM counters once per period through a shared active-low load strobe and per-channel preset buses. It sits between the host/DSP write port and the two PWM counter/comparator channels. It also raises per-channel data requests and sticky underrun/overrun flags.

## Interface
Parameters:
- SAMPLE_W, 7, sample and preset width; must match the PWM counter width.
- FIFO_DEPTH, 4, entries per channel when the FIFO is compiled in; power of two, 2 or greater.

Ports:
- MasterClock  in  1  sole clock; all state changes on its rising edge.
- RESETL  in  1  asynchronous, active-low reset.
- xck_en  in  1  PWM step enable; one MasterClock cycle high per XCK period.
- enable  in  1  audio run; low holds the timebase and mutes.
- wr  in  1  sample write strobe; one write per cycle at most.
- wr_chan  in  1  0 = left, 1 = right.
- wr_data  in  SAMPLE_W  sample = desired PW high time in XCK steps.
- clr_flags  in  1  clears underrun and overrun.
- ldl  out  1  active-low counter load strobe, registered.
- d_l, d_r  out  SAMPLE_W each  counter preset = bitwise NOT of the active sample, registered.
- drq  out  2  per-channel buffer-has-space, registered.
- underrun  out  2  sticky, per channel.
- overrun  out  2  sticky, per channel.
- period_start  out  1  one-cycle pulse on each load.

## Operation
- Timebase: a 7-bit phase counter advances by one on each xck_en cycle while enable is high. It wraps from 127 to 0.
- Transfer:
  - Occurs on the edge where the phase counter goes from 127 to 0.
  - For each channel, if its buffer is non-empty, the oldest sample pops into the active register.
  - If the buffer is empty, the active register keeps its value and the channel's underrun bit sets.
- Presets: d_l and d_r update on the same edge as the transfer. Each is loaded as the NOT of the new active sample.
- ldl is low while phase == 0 and enable is high. It is therefore held across exactly one XCK step, so the counter samples it once.
- period_start pulses on the transfer edge.
- Writes:
  - If the target buffer has space, the write is pushed.
  - If the target buffer is full, the write is dropped and that channel's overrun bit sets.
  - A write and a transfer on the same edge to an empty buffer: the transfer underruns (no bypass) and the write lands in the buffer.
  - A write and a pop on the same edge to a full buffer: both proceed and no overrun occurs.
- drq[c] is high while buffer c is not full. It reflects the buffer state after the current edge.
- Flags:
  - clr_flags clears underrun and overrun.
  - A set event and a clear on the same edge: the flag stays set.
- enable low:
  - The phase counter is forced to 0 and ldl is held high.
  - Active registers are forced to 0, so the presets are 7F (silence).
  - Buffers are retained.
- Re-enable: the first xck_en with enable high advances phase to 1. The first load occurs after the next wrap.

## Timing
- Reset values: phase 0, active samples 0, ldl 1, d_l 7F, d_r 7F, drq 11, underrun 00, overrun 00, period_start 0, buffers empty.
- Write to drq deassertion: 1 cycle.
- Minimum write to preset latency: 1 cycle, when the write precedes the wrap edge.
- Maximum write to preset latency: 128 XCK steps × buffer occupancy.
- Period: 128 xck_en pulses. ldl low duration equals the xck_en spacing.
- Reset asserted mid-period: all state returns to reset values immediately and asynchronously. Buffered samples are lost.

## Configuration
- PWM_SCHED_FIFO_EN defined: each channel has a FIFO_DEPTH-entry FIFO. drq is high while occupancy < FIFO_DEPTH.
- PWM_SCHED_FIFO_EN undefined: each channel has a single holding register plus a valid bit, so effective depth is 1. drq is the inverted valid bit. FIFO_DEPTH is ignored.
- Port list is identical in both builds.

## Structure
- Package pwm_sched_pkg holds:
  - SAMPLE_W.
  - PHASE_W = 7 and PHASE_LAST = 127.
  - Channel enum CH_LEFT = 0, CH_RIGHT = 1.
  - MUTE_PRESET = 7'h7F.
- Sub-module pwm_sample_fifo: one per channel, with push, pop, full, empty and dout. Its depth-1 variant is selected by the macro.
- The top level holds the timebase, the transfer logic, the flags and the output registers.

## Test plan
- Reset, then enable with no writes: at the first wrap, underrun = 11, d_l = d_r = 7F, ldl low for one XCK step, period_start pulses once.
- Write left = 05 and right = 7F, then let a wrap occur: d_l = 7A and d_r = 00 on the wrap edge, ldl low while phase is 0, underrun stays 00.
- Overflow a channel:
  - FIFO build: write 5 left samples in one period; overrun[0] = 1 and drq[0] = 0. The next four wraps present samples 1–4 in order.
  - Non-FIFO build: the 2nd write sets overrun.
- Write to an empty buffer on the wrap edge: underrun sets, the write is retained, and it is presented at the following wrap.
- Drop enable mid-period with phase = 60: ldl = 1, presets 7F, phase 0, buffer contents kept. Restore enable: the first load occurs 128 xck_en pulses later.
- Assert RESETL mid-period with full buffers and the flags set: all outputs return to reset values at once, drq = 11.

Source files
------------

// File: rtl/pwm_sched_pkg.sv
// Shared constants and types for the stereo PWM audio sample scheduler.
package pwm_sched_pkg;

    localparam int SAMPLE_W = 7;
    localparam int PHASE_W  = 7;

    localparam logic [PHASE_W-1:0]  PHASE_LAST  = 7'd127;
    localparam logic [SAMPLE_W-1:0] MUTE_PRESET = 7'h7F;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } ch_e;

endpackage

// File: rtl/pwm_sample_fifo.sv
// Per-channel sample buffer: DEPTH-entry FIFO with PWM_SCHED_FIFO_EN,
// otherwise a single holding register with a valid bit.
module pwm_sample_fifo #(
    parameter int W     = 7,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pwm_sample_fifo: DEPTH must be a power of two, 2 or greater");
    end

`ifdef PWM_SCHED_FIFO_EN
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;

    always_comb begin
        count_nxt = count;
        unique case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Flags are registered from the next count so they settle with the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= din;
    end

    assign dout = mem[rptr];
`else
    logic         valid;
    logic [W-1:0] hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            hold  <= '0;
        end else begin
            if (push)     hold  <= din;
            if (push)     valid <= 1'b1;
            else if (pop) valid <= 1'b0;
        end
    end

    assign dout  = hold;
    assign full  = valid;
    assign empty = !valid;
`endif

endmodule

// File: rtl/pwm_audio_sched.sv
// Stereo PWM audio sample scheduler: 128-step timebase, per-channel buffers,
// counter preset loading. Define PWM_SCHED_FIFO_EN for FIFO_DEPTH buffers.
module pwm_audio_sched #(
    parameter int SAMPLE_W   = pwm_sched_pkg::SAMPLE_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                MasterClock,
    input  logic                RESETL,
    input  logic                xck_en,
    input  logic                enable,
    input  logic                wr,
    input  logic                wr_chan,
    input  logic [SAMPLE_W-1:0] wr_data,
    input  logic                clr_flags,
    output logic                ldl,
    output logic [SAMPLE_W-1:0] d_l,
    output logic [SAMPLE_W-1:0] d_r,
    output logic [1:0]          drq,
    output logic [1:0]          underrun,
    output logic [1:0]          overrun,
    output logic                period_start
);

    import pwm_sched_pkg::*;

    logic [PHASE_W-1:0]          phase;
    logic [1:0][SAMPLE_W-1:0]    act;
    logic [1:0][SAMPLE_W-1:0]    act_nxt;
    logic [1:0][SAMPLE_W-1:0]    dout;
    logic [1:0]                  full;
    logic [1:0]                  empty;
    logic [1:0]                  push;
    logic [1:0]                  pop;
    logic [1:0]                  ovr_set;
    logic [1:0]                  und_set;
    logic                        wrap;

    assign wrap = enable && xck_en && (phase == PHASE_LAST);

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic sel;
        assign sel        = wr && (wr_chan == 1'(c));
        assign pop[c]     = wrap && !empty[c];
        // A pop on the same edge frees the slot, so a full buffer still accepts.
        assign push[c]    = sel && (!full[c] || pop[c]);
        assign ovr_set[c] = sel && full[c] && !pop[c];
        assign und_set[c] = wrap && empty[c];
        assign act_nxt[c] = !enable ? '0 : (pop[c] ? dout[c] : act[c]);

        pwm_sample_fifo #(
            .W     (SAMPLE_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (MasterClock),
            .rst_n (RESETL),
            .push  (push[c]),
            .pop   (pop[c]),
            .din   (wr_data),
            .dout  (dout[c]),
            .full  (full[c]),
            .empty (empty[c])
        );
    end

    always_ff @(posedge MasterClock or negedge RESETL) begin
        if (!RESETL) begin
            phase        <= '0;
            act          <= '0;
            ldl          <= 1'b1;
            d_l          <= SAMPLE_W'(MUTE_PRESET);
            d_r          <= SAMPLE_W'(MUTE_PRESET);
            underrun     <= '0;
            overrun      <= '0;
            period_start <= 1'b0;
        end else begin
            if (!enable)     phase <= '0;
            else if (xck_en) phase <= phase + PHASE_W'(1);
            act <= act_nxt;
            d_l <= ~act_nxt[CH_LEFT];
            d_r <= ~act_nxt[CH_RIGHT];
            // Low only from a wrap until the next step, so the counter sees it once.
            if (wrap)                   ldl <= 1'b0;
            else if (!enable || xck_en) ldl <= 1'b1;
            period_start <= wrap;
            underrun <= (underrun & ~{2{clr_flags}}) | und_set;
            overrun  <= (overrun & ~{2{clr_flags}}) | ovr_set;
        end
    end

    assign drq = ~full;

endmodule

// File: tb/tb_pwm_audio_sched.sv
// Directed self-checking bench for pwm_audio_sched (both buffer builds).
module tb_pwm_audio_sched;

`ifdef PWM_SCHED_FIFO_EN
    localparam int D = 4;
`else
    localparam int D = 1;
`endif

    logic       clk = 1'b0;
    logic       RESETL = 1'b0;
    logic       xck_en = 1'b0;
    logic       enable = 1'b0;
    logic       wr = 1'b0;
    logic       wr_chan = 1'b0;
    logic [6:0] wr_data = '0;
    logic       clr_flags = 1'b0;
    logic       ldl;
    logic [6:0] d_l;
    logic [6:0] d_r;
    logic [1:0] drq;
    logic [1:0] underrun;
    logic [1:0] overrun;
    logic       period_start;

    int errs = 0;
    int checks = 0;
    int ph = 0;

    always #5 clk = ~clk;

    pwm_audio_sched #(.SAMPLE_W(7), .FIFO_DEPTH(4)) dut (
        .MasterClock  (clk),
        .RESETL       (RESETL),
        .xck_en       (xck_en),
        .enable       (enable),
        .wr           (wr),
        .wr_chan      (wr_chan),
        .wr_data      (wr_data),
        .clr_flags    (clr_flags),
        .ldl          (ldl),
        .d_l          (d_l),
        .d_r          (d_r),
        .drq          (drq),
        .underrun     (underrun),
        .overrun      (overrun),
        .period_start (period_start)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xedge();
        xck_en = 1'b1;
        tick();
        xck_en = 1'b0;
        if (enable) ph = (ph + 1) % 128;
    endtask

    task automatic xstep();
        xedge();
        tick();
    endtask

    task automatic run_to(input int target);
        for (int n = 0; n < 130 && ph != target; n++) xstep();
    endtask

    task automatic write(input logic ch, input logic [6:0] d);
        wr = 1'b1;
        wr_chan = ch;
        wr_data = d;
        tick();
        wr = 1'b0;
    endtask

    task automatic clear();
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++; if (ldl !== 1'b1) begin errs++; $display("FAIL rst_ldl: got %b want 1", ldl); end
        checks++; if (d_l !== 7'h7F) begin errs++; $display("FAIL rst_d_l: got %h want 7f", d_l); end
        checks++; if (d_r !== 7'h7F) begin errs++; $display("FAIL rst_d_r: got %h want 7f", d_r); end
        checks++; if (drq !== 2'b11) begin errs++; $display("FAIL rst_drq: got %b want 11", drq); end
        checks++; if (underrun !== 2'b00) begin errs++; $display("FAIL rst_und: got %b want 00", underrun); end
        checks++; if (overrun !== 2'b00) begin errs++; $display("FAIL rst_ovr: got %b want 00", overrun); end
        checks++; if (period_start !== 1'b0) begin errs++; $display("FAIL rst_ps: got %b want 0", period_start); end
        RESETL = 1'b1;
        tick();
    endtask

    task automatic test_idle_wrap();
        enable = 1'b1;
        ph = 0;
        run_to(127);
        checks++; if (ldl !== 1'b1) begin errs++; $display("FAIL idle_pre_ldl: got %b want 1", ldl); end
        xedge();
        checks++; if (underrun !== 2'b11) begin errs++; $display("FAIL idle_und: got %b want 11", underrun); end
        checks++; if (d_l !== 7'h7F) begin errs++; $display("FAIL idle_d_l: got %h want 7f", d_l); end
        checks++; if (d_r !== 7'h7F) begin errs++; $display("FAIL idle_d_r: got %h want 7f", d_r); end
        checks++; if (ldl !== 1'b0) begin errs++; $display("FAIL idle_ldl: got %b want 0", ldl); end
        checks++; if (period_start !== 1'b1) begin errs++; $display("FAIL idle_ps: got %b want 1", period_start); end
        tick();
        checks++; if (ldl !== 1'b0) begin errs++; $display("FAIL idle_ldl_hold: got %b want 0", ldl); end
        checks++; if (period_start !== 1'b0) begin errs++; $display("FAIL idle_ps_pulse: got %b want 0", period_start); end
        xedge();
        checks++; if (ldl !== 1'b1) begin errs++; $display("FAIL idle_ldl_rel: got %b want 1", ldl); end
        clear();
        checks++; if (underrun !== 2'b00) begin errs++; $display("FAIL idle_clr: got %b want 00", underrun); end
    endtask

    task automatic test_basic();
        write(1'b0, 7'h05);
        checks++; if (drq !== (D == 1 ? 2'b10 : 2'b11)) begin errs++; $display("FAIL basic_drq_wr: got %b", drq); end
        write(1'b1, 7'h7F);
        run_to(127);
        xedge();
        checks++; if (d_l !== 7'h7A) begin errs++; $display("FAIL basic_d_l: got %h want 7a", d_l); end
        checks++; if (d_r !== 7'h00) begin errs++; $display("FAIL basic_d_r: got %h want 00", d_r); end
        checks++; if (underrun !== 2'b00) begin errs++; $display("FAIL basic_und: got %b want 00", underrun); end
        checks++; if (ldl !== 1'b0) begin errs++; $display("FAIL basic_ldl: got %b want 0", ldl); end
        checks++; if (period_start !== 1'b1) begin errs++; $display("FAIL basic_ps: got %b want 1", period_start); end
        checks++; if (drq !== 2'b11) begin errs++; $display("FAIL basic_drq_pop: got %b want 11", drq); end
        xstep();
        checks++; if (ldl !== 1'b1) begin errs++; $display("FAIL basic_ldl_rel: got %b want 1", ldl); end
    endtask

    task automatic test_overflow();
        logic [6:0] exp;
        for (int i = 1; i <= D; i++) write(1'b0, 7'(i));
        checks++; if (drq !== 2'b10) begin errs++; $display("FAIL ovf_drq_full: got %b want 10", drq); end
        write(1'b0, 7'(D + 1));
        checks++; if (overrun !== 2'b01) begin errs++; $display("FAIL ovf_set: got %b want 01", overrun); end
        checks++; if (drq !== 2'b10) begin errs++; $display("FAIL ovf_drq: got %b want 10", drq); end
        clear();
        checks++; if (overrun !== 2'b00) begin errs++; $display("FAIL ovf_clr: got %b want 00", overrun); end
        run_to(127);
        wr = 1'b1; wr_chan = 1'b0; wr_data = 7'h33;
        xedge();
        wr = 1'b0;
        checks++; if (d_l !== 7'h7E) begin errs++; $display("FAIL ovf_pop1: got %h want 7e", d_l); end
        checks++; if (overrun !== 2'b00) begin errs++; $display("FAIL ovf_push_pop: got %b want 00", overrun); end
        checks++; if (drq !== 2'b10) begin errs++; $display("FAIL ovf_drq_refill: got %b want 10", drq); end
        for (int k = 2; k <= D; k++) begin
            exp = ~7'(k);
            run_to(127);
            xedge();
            checks++; if (d_l !== exp) begin errs++; $display("FAIL ovf_pop%0d: got %h want %h", k, d_l, exp); end
        end
        run_to(127);
        xedge();
        checks++; if (d_l !== 7'h4C) begin errs++; $display("FAIL ovf_pop_last: got %h want 4c", d_l); end
        checks++; if (drq !== 2'b11) begin errs++; $display("FAIL ovf_drq_empty: got %b want 11", drq); end
        clear();
    endtask

    task automatic test_wrap_write();
        run_to(127);
        wr = 1'b1; wr_chan = 1'b1; wr_data = 7'h2A;
        xedge();
        wr = 1'b0;
        checks++; if (underrun !== 2'b11) begin errs++; $display("FAIL ww_und: got %b want 11", underrun); end
        checks++; if (d_r !== 7'h00) begin errs++; $display("FAIL ww_d_r_hold: got %h want 00", d_r); end
        checks++; if (drq !== (D == 1 ? 2'b01 : 2'b11)) begin errs++; $display("FAIL ww_drq: got %b", drq); end
        clear();
        run_to(127);
        xedge();
        checks++; if (d_r !== 7'h55) begin errs++; $display("FAIL ww_d_r: got %h want 55", d_r); end
        checks++; if (underrun !== 2'b01) begin errs++; $display("FAIL ww_und2: got %b want 01", underrun); end
        clear();
    endtask

    task automatic test_enable_drop();
        int low_seen;
        write(1'b0, 7'h10);
        run_to(60);
        enable = 1'b0;
        tick();
        checks++; if (ldl !== 1'b1) begin errs++; $display("FAIL en_ldl: got %b want 1", ldl); end
        checks++; if (d_l !== 7'h7F) begin errs++; $display("FAIL en_d_l: got %h want 7f", d_l); end
        checks++; if (d_r !== 7'h7F) begin errs++; $display("FAIL en_d_r: got %h want 7f", d_r); end
        checks++; if (drq !== (D == 1 ? 2'b10 : 2'b11)) begin errs++; $display("FAIL en_drq_kept: got %b", drq); end
        for (int i = 0; i < 3; i++) xstep();
        checks++; if (ldl !== 1'b1) begin errs++; $display("FAIL en_ldl_idle: got %b want 1", ldl); end
        enable = 1'b1;
        ph = 0;
        low_seen = 0;
        for (int i = 0; i < 127; i++) begin
            xedge();
            if (ldl !== 1'b1 || period_start !== 1'b0) low_seen++;
            tick();
        end
        checks++; if (low_seen !== 0) begin errs++; $display("FAIL en_early_load: got %0d want 0", low_seen); end
        xedge();
        checks++; if (period_start !== 1'b1) begin errs++; $display("FAIL en_ps: got %b want 1", period_start); end
        checks++; if (ldl !== 1'b0) begin errs++; $display("FAIL en_load: got %b want 0", ldl); end
        checks++; if (d_l !== 7'h6F) begin errs++; $display("FAIL en_d_l_kept: got %h want 6f", d_l); end
        checks++; if (d_r !== 7'h7F) begin errs++; $display("FAIL en_d_r_mute: got %h want 7f", d_r); end
        clear();
    endtask

    task automatic test_reset_mid();
        run_to(127);
        xedge();
        for (int i = 0; i <= D; i++) write(1'b0, 7'(i + 8));
        for (int i = 0; i < D; i++) write(1'b1, 7'(i + 8));
        for (int i = 0; i < 5; i++) xstep();
        checks++; if (overrun !== 2'b01) begin errs++; $display("FAIL rm_pre_ovr: got %b want 01", overrun); end
        checks++; if (underrun !== 2'b11) begin errs++; $display("FAIL rm_pre_und: got %b want 11", underrun); end
        checks++; if (drq !== 2'b00) begin errs++; $display("FAIL rm_pre_drq: got %b want 00", drq); end
        checks++; if (d_l !== 7'h6F) begin errs++; $display("FAIL rm_pre_d_l: got %h want 6f", d_l); end
        #2;
        RESETL = 1'b0;
        #1;
        checks++; if (ldl !== 1'b1) begin errs++; $display("FAIL rm_ldl: got %b want 1", ldl); end
        checks++; if (d_l !== 7'h7F) begin errs++; $display("FAIL rm_d_l: got %h want 7f", d_l); end
        checks++; if (d_r !== 7'h7F) begin errs++; $display("FAIL rm_d_r: got %h want 7f", d_r); end
        checks++; if (drq !== 2'b11) begin errs++; $display("FAIL rm_drq: got %b want 11", drq); end
        checks++; if (underrun !== 2'b00) begin errs++; $display("FAIL rm_und: got %b want 00", underrun); end
        checks++; if (overrun !== 2'b00) begin errs++; $display("FAIL rm_ovr: got %b want 00", overrun); end
        checks++; if (period_start !== 1'b0) begin errs++; $display("FAIL rm_ps: got %b want 0", period_start); end
        #2;
        RESETL = 1'b1;
        tick();
        ph = 0;
        run_to(127);
        xedge();
        checks++; if (underrun !== 2'b11) begin errs++; $display("FAIL rm_lost: got %b want 11", underrun); end
        checks++; if (d_l !== 7'h7F) begin errs++; $display("FAIL rm_lost_d_l: got %h want 7f", d_l); end
    endtask

    initial begin
        test_reset();
        test_idle_wrap();
        test_basic();
        test_overflow();
        test_wrap_write();
        test_enable_drop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
